// File: rtl/pcap_rx_arb.sv
// Two-channel packet-capture record arbiter: merges {meta, data} FIFO pairs into
// sop/eop framed records. Optional length header word enabled by PCAP_ARB_LEN_HDR_EN.
module pcap_rx_arb #(
  parameter logic [15:0] MAX_LEN = 16'd9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active_i,
  input  logic [79:0] ch0_meta_dout_i,
  input  logic        ch0_meta_empty_i,
  output logic        ch0_meta_rd_en_o,
  input  logic [63:0] ch0_data_dout_i,
  input  logic        ch0_data_empty_i,
  output logic        ch0_data_rd_en_o,
  input  logic [79:0] ch1_meta_dout_i,
  input  logic        ch1_meta_empty_i,
  output logic        ch1_meta_rd_en_o,
  input  logic [63:0] ch1_data_dout_i,
  input  logic        ch1_data_empty_i,
  output logic        ch1_data_rd_en_o,
  output logic [63:0] out_dat_o,
  output logic        out_vld_o,
  output logic        out_sop_o,
  output logic        out_eop_o,
  output logic        out_chn_o,
  input  logic        out_rdy_i,
  output logic [31:0] rec_cnt_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    HDR_TS,
`ifdef PCAP_ARB_LEN_HDR_EN
    HDR_LEN,
`endif
    DATA,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [13:0] rem_q, rem_d;
  logic [31:0] rec_cnt_q, rec_cnt_d;
  logic        err_q, err_d;
`ifdef PCAP_ARB_LEN_HDR_EN
  logic [15:0] len_q, len_d;
`endif

  logic        el0, el1, sel;
  logic [15:0] sel_len;
  logic [13:0] sel_words;
  logic [63:0] g_ts, g_data;
  logic        g_data_empty;
  logic        vld, sop, eop, hs, meta_pop, data_pop;
  logic [63:0] dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rem_q        <= '0;
      rec_cnt_q    <= '0;
      err_q        <= 1'b0;
`ifdef PCAP_ARB_LEN_HDR_EN
      len_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rem_q        <= rem_d;
      rec_cnt_q    <= rec_cnt_d;
      err_q        <= err_d;
`ifdef PCAP_ARB_LEN_HDR_EN
      len_q        <= len_d;
`endif
    end
  end

  // On a tie the channel that did not win last time is granted.
  always_comb begin
    el0          = ~ch0_meta_empty_i & active_i;
    el1          = ~ch1_meta_empty_i & active_i;
    sel          = (el0 & el1) ? ~last_grant_q : el1;
    sel_len      = sel ? ch1_meta_dout_i[79:64] : ch0_meta_dout_i[79:64];
    sel_words    = 14'(({1'b0, sel_len} + 17'd7) >> 3);
    g_ts         = grant_q ? ch1_meta_dout_i[63:0] : ch0_meta_dout_i[63:0];
    g_data       = grant_q ? ch1_data_dout_i : ch0_data_dout_i;
    g_data_empty = grant_q ? ch1_data_empty_i : ch0_data_empty_i;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rem_d        = rem_q;
    rec_cnt_d    = rec_cnt_q;
    err_d        = err_q;
`ifdef PCAP_ARB_LEN_HDR_EN
    len_d        = len_q;
`endif
    vld          = 1'b0;
    sop          = 1'b0;
    eop          = 1'b0;
    dat          = '0;
    meta_pop     = 1'b0;
    data_pop     = 1'b0;
    hs           = 1'b0;
    unique case (state_q)
      IDLE: if (active_i) state_d = ARB;
      ARB: begin
        if (el0 | el1) begin
          if (sel_len == 16'd0 || sel_len > MAX_LEN) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d      = HDR_TS;
            grant_d      = sel;
            last_grant_d = sel;
            rem_d        = sel_words;
`ifdef PCAP_ARB_LEN_HDR_EN
            len_d        = sel_len;
`endif
          end
        end else if (!active_i) begin
          state_d = IDLE;
        end
      end
      HDR_TS: begin
        vld = 1'b1;
        sop = 1'b1;
        dat = g_ts;
        hs  = out_rdy_i;
        if (hs) begin
          meta_pop = 1'b1;
`ifdef PCAP_ARB_LEN_HDR_EN
          state_d  = HDR_LEN;
`else
          state_d  = DATA;
`endif
        end
      end
`ifdef PCAP_ARB_LEN_HDR_EN
      HDR_LEN: begin
        vld = 1'b1;
        dat = {47'b0, grant_q, len_q};
        hs  = out_rdy_i;
        if (hs) state_d = DATA;
      end
`endif
      DATA: begin
        vld = ~g_data_empty;
        dat = g_data;
        eop = (rem_q == 14'd1);
        hs  = vld & out_rdy_i;
        if (hs) begin
          data_pop = 1'b1;
          rem_d    = rem_q - 14'd1;
          if (eop) begin
            rec_cnt_d = rec_cnt_q + 32'd1;
            state_d   = ARB;
          end
        end
      end
      ERR: err_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign out_vld_o        = vld;
  assign out_sop_o        = sop;
  assign out_eop_o        = eop;
  assign out_dat_o        = dat;
  assign out_chn_o        = vld & grant_q;
  assign ch0_meta_rd_en_o = meta_pop & ~grant_q;
  assign ch1_meta_rd_en_o = meta_pop & grant_q;
  assign ch0_data_rd_en_o = data_pop & ~grant_q;
  assign ch1_data_rd_en_o = data_pop & grant_q;
  assign rec_cnt_o        = rec_cnt_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_pcap_rx_arb.sv
// Directed bench for pcap_rx_arb: FWFT FIFO models, vector table of single records,
// plus hand sequences for alternation, active drop, reset mid-record and length errors.
module tb_pcap_rx_arb;

`ifdef PCAP_ARB_LEN_HDR_EN
  localparam int HDR_WORDS = 2;
`else
  localparam int HDR_WORDS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        active = 1'b0;
  logic        out_rdy = 1'b1;
  logic [79:0] m0_dout, m1_dout;
  logic [63:0] d0_dout, d1_dout;
  logic        m0_empty, m1_empty, d0_empty, d1_empty;
  logic        m0_rd, m1_rd, d0_rd, d1_rd;
  logic [63:0] out_dat;
  logic        out_vld, out_sop, out_eop, out_chn, err;
  logic [31:0] rec_cnt;

  logic [79:0] m0_mem [0:63];
  logic [79:0] m1_mem [0:63];
  logic [63:0] d0_mem [0:4095];
  logic [63:0] d1_mem [0:4095];
  int m0_wp = 0, m1_wp = 0, d0_wp = 0, d1_wp = 0;
  int m0_rp = 0, m1_rp = 0, d0_rp = 0, d1_rp = 0;
  logic pop_empty = 1'b0;

  int n_vec = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  logic [63:0] cap_dat[$];
  logic        cap_sop[$];
  logic        cap_eop[$];
  logic        cap_chn[$];

  typedef struct {
    logic        c;
    logic [15:0] len;
    logic [63:0] ts;
    int          nw;
    int          mode;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  assign m0_dout  = m0_mem[m0_rp[5:0]];
  assign m1_dout  = m1_mem[m1_rp[5:0]];
  assign d0_dout  = d0_mem[d0_rp[11:0]];
  assign d1_dout  = d1_mem[d1_rp[11:0]];
  assign m0_empty = (m0_rp == m0_wp);
  assign m1_empty = (m1_rp == m1_wp);
  assign d0_empty = (d0_rp == d0_wp);
  assign d1_empty = (d1_rp == d1_wp);

  always @(posedge clk) begin
    if (m0_rd) m0_rp <= m0_rp + 1;
    if (m1_rd) m1_rp <= m1_rp + 1;
    if (d0_rd) d0_rp <= d0_rp + 1;
    if (d1_rd) d1_rp <= d1_rp + 1;
    if ((m0_rd && m0_empty) || (m1_rd && m1_empty) || (d0_rd && d0_empty) || (d1_rd && d1_empty))
      pop_empty <= 1'b1;
  end

  pcap_rx_arb dut (
    .clk(clk), .rst_n(rst_n), .active_i(active),
    .ch0_meta_dout_i(m0_dout), .ch0_meta_empty_i(m0_empty), .ch0_meta_rd_en_o(m0_rd),
    .ch0_data_dout_i(d0_dout), .ch0_data_empty_i(d0_empty), .ch0_data_rd_en_o(d0_rd),
    .ch1_meta_dout_i(m1_dout), .ch1_meta_empty_i(m1_empty), .ch1_meta_rd_en_o(m1_rd),
    .ch1_data_dout_i(d1_dout), .ch1_data_empty_i(d1_empty), .ch1_data_rd_en_o(d1_rd),
    .out_dat_o(out_dat), .out_vld_o(out_vld), .out_sop_o(out_sop), .out_eop_o(out_eop),
    .out_chn_o(out_chn), .out_rdy_i(out_rdy), .rec_cnt_o(rec_cnt), .err_o(err)
  );

  function automatic logic [63:0] dword(input logic c, input int rid, input int i);
    return {7'h68, c, 24'(rid), 32'(i)};
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushRecord(input logic c, input logic [15:0] len, input logic [63:0] ts,
                            input int nw, input int rid);
    if (!c) begin
      m0_mem[m0_wp[5:0]] = {len, ts};
      m0_wp++;
      for (int i = 0; i < nw; i++) begin
        d0_mem[d0_wp[11:0]] = dword(c, rid, i);
        d0_wp++;
      end
    end else begin
      m1_mem[m1_wp[5:0]] = {len, ts};
      m1_wp++;
      for (int i = 0; i < nw; i++) begin
        d1_mem[d1_wp[11:0]] = dword(c, rid, i);
        d1_wp++;
      end
    end
  endtask

  task automatic flushFifos();
    m0_wp = m0_rp;
    m1_wp = m1_rp;
    d0_wp = d0_rp;
    d1_wp = d1_rp;
  endtask

  // mode 0: ready always, 1: ready every other cycle, 2: random ready
  task automatic applyStimulus(input int n_rec, input int mode, input bit drop, input int budget);
    int n_eop;
    bit stalled;
    logic [67:0] prev;
    n_eop = 0;
    stalled = 1'b0;
    prev = '0;
    cap_dat.delete(); cap_sop.delete(); cap_eop.delete(); cap_chn.delete();
    for (int cyc = 0; cyc < budget && n_eop < n_rec; cyc++) begin
      @(posedge clk);
      #1;
      out_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled)
        checkOutput("stall_hold", {out_vld, out_sop, out_eop, out_chn, out_dat}, {12'b0, prev});
      if (out_vld && out_rdy) begin
        cap_dat.push_back(out_dat);
        cap_sop.push_back(out_sop);
        cap_eop.push_back(out_eop);
        cap_chn.push_back(out_chn);
        if (out_eop) n_eop++;
        if (drop) active = 1'b0;
      end
      stalled = out_vld && !out_rdy;
      prev = {out_vld, out_sop, out_eop, out_chn, out_dat};
    end
    if (n_eop < n_rec) checkOutput("record_timeout", 80'(n_eop), 80'(n_rec));
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
  endtask

  task automatic checkRecord(input int b, input logic c, input logic [15:0] len,
                             input logic [63:0] ts, input int nw, input int rid);
    int bad;
    int idx;
    if (cap_dat.size() < b + HDR_WORDS + nw) begin
      checkOutput("record_size", 80'(cap_dat.size() - b), 80'(HDR_WORDS + nw));
      return;
    end
    checkOutput("hdr_ts", {16'b0, cap_dat[b]}, {16'b0, ts});
    checkOutput("hdr_flags", {77'b0, cap_sop[b], cap_eop[b], cap_chn[b]}, {77'b0, 1'b1, 1'b0, c});
`ifdef PCAP_ARB_LEN_HDR_EN
    checkOutput("len_word", {16'b0, cap_dat[b+1]}, {16'b0, 47'b0, c, len});
    checkOutput("len_flags", {77'b0, cap_sop[b+1], cap_eop[b+1], cap_chn[b+1]}, {77'b0, 1'b0, 1'b0, c});
`endif
    bad = 0;
    for (int i = 0; i < nw; i++) begin
      idx = b + HDR_WORDS + i;
      if (cap_dat[idx] !== dword(c, rid, i) || cap_chn[idx] !== c || cap_sop[idx] !== 1'b0 ||
          cap_eop[idx] !== 1'(i == nw - 1))
        bad++;
    end
    checkOutput("data_words_bad", 80'(bad), 80'(0));
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput(name, {out_vld, out_sop, out_eop, out_chn, out_dat, m0_rd, m1_rd, d0_rd, d1_rd},
                80'b0);
  endtask

  initial begin
    int seen;
    int rp_save;
    vecs[0] = '{1'b0, 16'd64,   64'h0000_0001_0000_0040, 8,    0};
    vecs[1] = '{1'b1, 16'd9,    64'h0000_0002_0000_0009, 2,    0};
    vecs[2] = '{1'b0, 16'd9,    64'h0000_0003_0000_0009, 2,    1};
    vecs[3] = '{1'b1, 16'd1,    64'h0000_0004_0000_0001, 1,    1};
    vecs[4] = '{1'b0, 16'd65,   64'h0000_0005_0000_0041, 9,    2};
    vecs[5] = '{1'b1, 16'd9600, 64'h0000_0006_0000_2580, 1200, 0};
    vecs[6] = '{1'b0, 16'd8,    64'h0000_0007_0000_0008, 1,    2};

    // reset values
    #12;
    checkIdleOutputs("reset_outputs");
    checkOutput("reset_cnt_err", {47'b0, rec_cnt, err}, 80'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // inactive: pending record must not be taken
    pushRecord(1'b0, 16'd8, 64'hABCD, 1, 100);
    repeat (6) @(negedge clk);
    checkOutput("inactive_hold", {out_vld, 32'(m0_rp)}, 33'b0);
    active = 1'b1;
    applyStimulus(1, 0, 1'b0, 40);
    checkRecord(0, 1'b0, 16'd8, 64'hABCD, 1, 100);
    checkOutput("rec_cnt_first", {48'b0, rec_cnt}, 80'd1);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = 0;

    for (int v = 0; v < 7; v++) begin
      pushRecord(vecs[v].c, vecs[v].len, vecs[v].ts, vecs[v].nw, v);
      applyStimulus(1, vecs[v].mode, 1'b0, 3000);
      checkRecord(0, vecs[v].c, vecs[v].len, vecs[v].ts, vecs[v].nw, v);
      checkOutput("record_size", 80'(cap_dat.size()), 80'(HDR_WORDS + vecs[v].nw));
      exp_cnt++;
      checkOutput("rec_cnt", {48'b0, rec_cnt}, 80'(exp_cnt));
    end

    // active drops after the header: record still completes, then nothing new starts
    pushRecord(1'b1, 16'd64, 64'h5151, 8, 20);
    applyStimulus(1, 0, 1'b1, 60);
    checkRecord(0, 1'b1, 16'd64, 64'h5151, 8, 20);
    exp_cnt++;
    checkOutput("rec_cnt_drop", {48'b0, rec_cnt}, 80'(exp_cnt));
    pushRecord(1'b0, 16'd8, 64'h6161, 1, 21);
    rp_save = m0_rp;
    repeat (6) @(negedge clk);
    checkOutput("drop_idle", {out_vld, 32'(m0_rp)}, {1'b0, 32'(rp_save)});
    active = 1'b1;
    applyStimulus(1, 0, 1'b0, 40);
    checkRecord(0, 1'b0, 16'd8, 64'h6161, 1, 21);

    // tie-breaking alternation starting from channel 0 after reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pushRecord(1'b0, 16'd8, 64'(32 + k), 1, 30 + k);
      pushRecord(1'b1, 16'd8, 64'(48 + k), 1, 40 + k);
    end
    applyStimulus(6, 0, 1'b0, 200);
    for (int k = 0; k < 6; k++)
      checkRecord(k * (HDR_WORDS + 1), 1'(k % 2), 16'd8,
                  (k % 2) ? 64'(48 + k / 2) : 64'(32 + k / 2), 1, (k % 2) ? 40 + k / 2 : 30 + k / 2);
    checkOutput("rec_cnt_alt", {48'b0, rec_cnt}, 80'd6);

    // reset in the middle of DATA
    pushRecord(1'b0, 16'd64, 64'h7777, 8, 50);
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen < 4; cyc++) begin
      @(negedge clk);
      if (out_vld && out_rdy) seen++;
    end
    checkOutput("mid_data_reached", {79'b0, out_vld & ~out_sop}, 80'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("reset_mid_data");
    checkOutput("reset_mid_cnt_err", {47'b0, rec_cnt, err}, 80'b0);
    flushFifos();
    @(negedge clk);
    rst_n = 1'b1;

    // illegal lengths lock into the error state until reset
    for (int e = 0; e < 2; e++) begin
      pushRecord(1'(e), (e == 0) ? 16'd0 : 16'd9601, 64'h9999, 2, 60 + e);
      rp_save = e ? m1_rp : m0_rp;
      seen = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
        @(negedge clk);
        if (out_vld || m0_rd || m1_rd || d0_rd || d1_rd) seen++;
      end
      checkOutput("err_set", {79'b0, err}, 80'd1);
      checkOutput("err_no_output", 80'(seen), 80'd0);
      checkOutput("err_no_pop", 80'(e ? m1_rp : m0_rp), 80'(rp_save));
      rst_n = 1'b0;
      #1;
      checkOutput("err_cleared", {79'b0, err}, 80'd0);
      flushFifos();
      @(negedge clk);
      rst_n = 1'b1;
    end

    checkOutput("no_pop_when_empty", {79'b0, pop_empty}, 80'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
